mux3_rr_arbiter: RTL

Round-robin, packet-locking arbiter that shares one 3:1 multiplexed data channel between three valid/ready requesters. It sequences the 2-bit select of a per-bit 3:1 mux datapath and holds the grant until the granted requester's last beat. It sits in front of any shared sink (bus, output port, register file write port) that three producers must take turns on.

---
 rtl/mux3_arb_pkg.sv | 65 ++++++
 rtl/mux3_rr_arbiter_rr_pick3.sv | 45 ++++
 rtl/mux3_rr_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mux3_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux3_arb_pkg
// Shared types, constants and helpers for the 3-requester round-robin
// packet-locking arbiter (mux3_rr_arbiter) and its pick logic (rr_pick3).
//
// Contents:
//   arb_state_e     - arbiter FSM states (IDLE, LOCKED)
//   SEL_REQ0/1/2    - mux select encodings driven on sel_o
//   RR_PTR_RST      - round-robin pointer value after reset (req0 wins first)
//   idx_to_sel()    - requester index -> mux select encoding
//   sel_to_onehot() - mux select encoding -> one-hot requester mask
//   mux3_bit()      - single-bit 3:1 mux slice steered by a select encoding
// -----------------------------------------------------------------------------
package mux3_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_REQ0   = 2'b00;
    localparam logic [1:0] SEL_REQ1   = 2'b01;
    localparam logic [1:0] SEL_REQ2   = 2'b10;

    // Pointer holds the index of the last granted requester; starting at 2
    // makes req0 the first in line after reset.
    localparam logic [1:0] RR_PTR_RST = 2'd2;

    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            2'd0:    sel = SEL_REQ0;
            2'd1:    sel = SEL_REQ1;
            default: sel = SEL_REQ2;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_REQ0: oh = 3'b001;
            SEL_REQ1: oh = 3'b010;
            SEL_REQ2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

    // The unused encoding 2'b11 is never produced; it falls back to input 0
    // so the slice has no don't-care leg.
    function automatic logic mux3_bit(input logic [1:0] sel,
                                      input logic       in0,
                                      input logic       in1,
                                      input logic       in2);
        logic y;
        case (sel)
            SEL_REQ1: y = in1;
            SEL_REQ2: y = in2;
            default:  y = in0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational round-robin winner selection among three requesters.
// The search starts just after the pointer: order is p+1, p+2, p (mod 3),
// so the most recently granted requester has the lowest priority.
//
// Ports:
//   valid_i     in  3  request vector
//   ptr_i       in  2  index of the last granted requester (0..2)
//   winner_o    out 2  index of the winning requester (0 when none valid)
//   any_valid_o out 1  at least one request present
// -----------------------------------------------------------------------------
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [2:0] valid_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] winner_o,
    output logic       any_valid_o
);

    always_comb begin
        winner_o    = '0;
        any_valid_o = |valid_i;
        case (ptr_i)
            2'd0: begin
                if      (valid_i[1]) winner_o = 2'd1;
                else if (valid_i[2]) winner_o = 2'd2;
                else if (valid_i[0]) winner_o = 2'd0;
            end
            2'd1: begin
                if      (valid_i[2]) winner_o = 2'd2;
                else if (valid_i[0]) winner_o = 2'd0;
                else if (valid_i[1]) winner_o = 2'd1;
            end
            // Pointer value 3 cannot occur; it is treated like 2.
            default: begin
                if      (valid_i[0]) winner_o = 2'd0;
                else if (valid_i[1]) winner_o = 2'd1;
                else if (valid_i[2]) winner_o = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux3_rr_arbiter
// Round-robin, packet-locking arbiter sharing one 3:1 multiplexed data channel
// between three valid/ready requesters. A grant is taken in IDLE (one bubble
// cycle) and held in LOCKED until the granted requester's last beat transfers.
// In LOCKED the valid/last/data/ready paths are purely combinational.
//
// Ports:
//   clk_i    in  1        clock, rising edge
//   rst_i    in  1        synchronous active-high reset
//   valid_i  in  3        per-requester beat valid
//   last_i   in  3        per-requester last-beat flag
//   data_i   in  3*WIDTH  requester n at [n*WIDTH +: WIDTH]
//   ready_o  out 3        per-requester ready (at most one bit set)
//   sel_o    out 2        registered mux select (00/01/10)
//   valid_o  out 1        output beat valid
//   last_o   out 1        output last flag
//   data_o   out WIDTH    output data
//   ready_i  in  1        sink ready
//   busy_o   out 1        grant held (LOCKED)
// -----------------------------------------------------------------------------
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2:0]           valid_i,
    input  logic [2:0]           last_i,
    input  logic [3*WIDTH-1:0]   data_i,
    output logic [2:0]           ready_o,
    output logic [1:0]           sel_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [WIDTH-1:0]     data_o,
    input  logic                 ready_i,
    output logic                 busy_o
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;

    logic [1:0]       w_winner;
    logic             w_any_valid;
    logic             w_locked;
    logic             w_mux_valid;
    logic             w_mux_last;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_xfer_last;

    rr_pick3 u_pick (
        .valid_i     (valid_i),
        .ptr_i       (r_ptr),
        .winner_o    (w_winner),
        .any_valid_o (w_any_valid)
    );

    // Datapath: one 3:1 slice per data bit, all steered by the registered
    // select; valid and last ride through identical slices.
    for (genvar b = 0; b < WIDTH; b++) begin : g_data_slice
        assign w_mux_data[b] = mux3_bit(r_sel,
                                        data_i[b],
                                        data_i[WIDTH + b],
                                        data_i[2*WIDTH + b]);
    end

    assign w_mux_valid = mux3_bit(r_sel, valid_i[0], valid_i[1], valid_i[2]);
    assign w_mux_last  = mux3_bit(r_sel, last_i[0],  last_i[1],  last_i[2]);

    assign w_locked    = (r_state == LOCKED);

    assign valid_o     = w_locked & w_mux_valid;
    assign last_o      = w_locked & w_mux_last;
    assign data_o      = w_mux_data;
    assign ready_o     = (w_locked && ready_i) ? sel_to_onehot(r_sel) : 3'b000;
    assign sel_o       = r_sel;
    assign busy_o      = w_locked;

    assign w_xfer_last = valid_o & ready_i & last_o;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = w_winner;
                    w_sel_nxt   = idx_to_sel(w_winner);
                end
            end
            LOCKED: begin
                // Pointer advances only when the packet completes, so a stalled
                // or bubbling packet keeps its place.
                if (w_xfer_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_grant;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= RR_PTR_RST;
            r_sel   <= SEL_REQ0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

endmodule
